jesd204b_rx_lane_aligner: RTL and testbench



---
 rtl/jesd204b_rx_lane_aligner.sv | 176 +++++++++++++++++
 tb/tb_jesd204b_rx_lane_aligner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_rx_lane_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jesd204b_rx_lane_aligner
//  Brief    : Multi-lane JESD204B RX comma alignment (RXSLIDE hunt) and CGS,
//             shared SYNC~ generation and aligned lane data forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module jesd204b_rx_lane_aligner #(
    parameter int LANES      = 2,
    parameter int BYTES      = 4,
    parameter int SLIDE_WAIT = 32,
    parameter int CGS_K_CNT  = 4,
    parameter int ERR_MAX    = 4,
    parameter int SLIDE_MAX  = 40
) (
    input  logic                        i_dclk,
    input  logic                        i_rst_n,
    input  logic                        i_gt_ready,
    input  logic [LANES*8*BYTES-1:0]    i_rxdata,
    input  logic [LANES*BYTES-1:0]      i_rxcharisk,
    input  logic [LANES*BYTES-1:0]      i_rxerr,
    output logic [LANES-1:0]            o_rxslide,
    output logic [LANES-1:0]            o_lane_sync,
    output logic                        o_nsync,
    output logic [LANES*8*BYTES-1:0]    o_data,
    output logic                        o_data_valid,
    output logic [LANES-1:0]            o_align_fail
);

    localparam int c_DW = 8 * BYTES;
    localparam int c_TW = $clog2(SLIDE_WAIT + 1);
    localparam int c_KW = $clog2(CGS_K_CNT + 1);
    localparam int c_EW = $clog2(ERR_MAX + 1);

    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(SLIDE_WAIT - 1);
    localparam logic [c_KW-1:0] c_K_LOCK     = c_KW'(CGS_K_CNT);
    localparam logic [c_EW-1:0] c_E_DROP     = c_EW'(ERR_MAX);
    localparam logic [5:0]      c_SLIDE_LAST = 6'(SLIDE_MAX - 1);
    localparam logic [c_DW-1:0] c_COMMA_WORD = {BYTES{8'hBC}};

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_HUNT  = 3'd1;
    localparam logic [2:0] c_ST_SLIDE = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_SYNC  = 3'd4;

    logic [LANES-1:0]           w_lane_k;
    logic [LANES-1:0]           w_lane_sync;
    logic                       r_nsync;
    logic                       r_data_valid;
    logic [LANES*8*BYTES-1:0]   r_data;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [2:0]         r_state;
        logic [c_TW-1:0]    r_timer;
        logic [c_KW-1:0]    r_kcnt;
        logic [c_EW-1:0]    r_ecnt;
        logic [5:0]         r_slide_cnt;
        logic               r_fail;

        logic [c_DW-1:0]    w_word;
        logic [BYTES-1:0]   w_k;
        logic [BYTES-1:0]   w_err;
        logic               w_aligned;
        logic               w_errored;
        logic [c_KW-1:0]    w_kcnt_nxt;
        logic [c_EW-1:0]    w_ecnt_nxt;

        assign w_word     = i_rxdata[n*c_DW +: c_DW];
        assign w_k        = i_rxcharisk[n*BYTES +: BYTES];
        assign w_err      = i_rxerr[n*BYTES +: BYTES];
        assign w_aligned  = (w_word == c_COMMA_WORD) && (&w_k) && !(|w_err);
        assign w_errored  = |w_err;
        assign w_kcnt_nxt = r_kcnt + c_KW'(1);
        assign w_ecnt_nxt = r_ecnt + c_EW'(1);

        always_ff @(posedge i_dclk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state     <= c_ST_IDLE;
                r_timer     <= '0;
                r_kcnt      <= '0;
                r_ecnt      <= '0;
                r_slide_cnt <= '0;
                r_fail      <= 1'b0;
            end else if (!i_gt_ready) begin
                r_state <= c_ST_IDLE;
                r_timer <= '0;
                r_kcnt  <= '0;
                r_ecnt  <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_state <= c_ST_HUNT;
                        r_timer <= '0;
                        r_kcnt  <= '0;
                    end
                    c_ST_HUNT: begin
                        // Lock wins over a hunt-window timeout in the same cycle
                        if (w_aligned && (w_kcnt_nxt == c_K_LOCK)) begin
                            r_state <= c_ST_SYNC;
                            r_kcnt  <= w_kcnt_nxt;
                            r_ecnt  <= '0;
                        end else begin
                            r_kcnt <= w_aligned ? w_kcnt_nxt : '0;
                            if (r_timer == c_TIMER_LAST) begin
                                r_state <= c_ST_SLIDE;
                            end else begin
                                r_timer <= r_timer + c_TW'(1);
                            end
                        end
                    end
                    c_ST_SLIDE: begin
                        r_state <= c_ST_WAIT;
                        r_timer <= '0;
                        r_kcnt  <= '0;
                        if (r_slide_cnt == c_SLIDE_LAST) begin
                            r_slide_cnt <= '0;
                            r_fail      <= 1'b1;
                        end else begin
                            r_slide_cnt <= r_slide_cnt + 6'd1;
                        end
                    end
                    c_ST_WAIT: begin
                        if (r_timer == c_TIMER_LAST) begin
                            r_state <= c_ST_HUNT;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + c_TW'(1);
                        end
                    end
                    c_ST_SYNC: begin
                        if (w_errored) begin
                            if (w_ecnt_nxt == c_E_DROP) begin
                                r_state <= c_ST_HUNT;
                                r_timer <= '0;
                                r_kcnt  <= '0;
                                r_ecnt  <= '0;
                            end else begin
                                r_ecnt <= w_ecnt_nxt;
                            end
                        end else begin
                            r_ecnt <= '0;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end

        assign w_lane_k[n]     = w_aligned;
        assign w_lane_sync[n]  = (r_state == c_ST_SYNC);
        assign o_rxslide[n]    = (r_state == c_ST_SLIDE);
        assign o_lane_sync[n]  = w_lane_sync[n];
        assign o_align_fail[n] = r_fail;
    end

    // Valid is judged on the same input word that lands on o_data
    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_nsync      <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
        end else begin
            r_nsync      <= &w_lane_sync;
            r_data_valid <= (&w_lane_sync) && r_nsync && !(|w_lane_k);
            r_data       <= i_rxdata;
        end
    end

    assign o_nsync      = r_nsync;
    assign o_data_valid = r_data_valid;
    assign o_data       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_jesd204b_rx_lane_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_jesd204b_rx_lane_aligner
//  Brief    : Scoreboard bench for the two-lane JESD204B RX lane aligner.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jesd204b_rx_lane_aligner;

    localparam logic [31:0] c_K32 = 32'hBCBCBCBC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gt_ready = 1'b0;
    logic [63:0] rxdata = '0;
    logic [7:0]  rxk = '0;
    logic [7:0]  rxerr = '0;

    logic [1:0]  o_rxslide;
    logic [1:0]  o_lane_sync;
    logic        o_nsync;
    logic [63:0] o_data;
    logic        o_data_valid;
    logic [1:0]  o_align_fail;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_data[$];
    logic [1:0]  exp_mask[$];
    int          exp_gap[$];

    jesd204b_rx_lane_aligner #(
        .LANES(2), .BYTES(4), .SLIDE_WAIT(32), .CGS_K_CNT(4), .ERR_MAX(4), .SLIDE_MAX(40)
    ) dut (
        .i_dclk       (clk),
        .i_rst_n      (rst_n),
        .i_gt_ready   (gt_ready),
        .i_rxdata     (rxdata),
        .i_rxcharisk  (rxk),
        .i_rxerr      (rxerr),
        .o_rxslide    (o_rxslide),
        .o_lane_sync  (o_lane_sync),
        .o_nsync      (o_nsync),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_align_fail (o_align_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d0, input logic [3:0] k0, input logic [3:0] e0,
                         input logic [31:0] d1, input logic [3:0] k1, input logic [3:0] e1);
        rxdata = {d1, d0};
        rxk    = {k1, k0};
        rxerr  = {e1, e0};
    endtask

    // Drive one word and tell the scoreboard it must come out as valid data
    task automatic send_valid(input logic [31:0] d0, input logic [3:0] k0, input logic [3:0] e0,
                              input logic [31:0] d1, input logic [3:0] k1, input logic [3:0] e1);
        drive(d0, k0, e0, d1, k1, e1);
        exp_data.push_back({d1, d0});
        tick();
    endtask

    task automatic push_slides(input logic [1:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            exp_mask.push_back(mask);
            exp_gap.push_back(i == 0 ? 0 : 65);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents valid data or a slide pulse
    initial begin
        int          cyc;
        int          last;
        logic [1:0]  m;
        int          g;
        cyc  = 0;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (o_data_valid) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: actual o_data %h required no valid word", o_data);
                end else begin
                    chk("data", o_data, exp_data.pop_front());
                end
            end
            if (o_rxslide != 2'b00) begin
                if (exp_mask.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_slide: actual %b required 00", o_rxslide);
                end else begin
                    m = exp_mask.pop_front();
                    g = exp_gap.pop_front();
                    chk("slide_mask", 64'(o_rxslide), 64'(m));
                    if (g != 0) chk("slide_gap", 64'(cyc - last), 64'(g));
                end
                last = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        bit found;

        repeat (3) tick();
        chk("rst_rxslide", 64'(o_rxslide), 64'd0);
        chk("rst_lane_sync", 64'(o_lane_sync), 64'd0);
        chk("rst_nsync", 64'(o_nsync), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_valid", 64'(o_data_valid), 64'd0);
        chk("rst_fail", 64'(o_align_fail), 64'd0);
        rst_n = 1'b1;
        tick();

        // Both lanes aligned from the start
        drive(c_K32, 4'hF, 4'h0, c_K32, 4'hF, 4'h0);
        gt_ready = 1'b1;
        repeat (4) tick();
        chk("lock_early", 64'(o_lane_sync), 64'd0);
        tick();
        chk("lock", 64'(o_lane_sync), 64'd3);
        chk("nsync_pre", 64'(o_nsync), 64'd0);
        tick();
        chk("nsync_rise", 64'(o_nsync), 64'd1);
        chk("valid_on_k", 64'(o_data_valid), 64'd0);

        // User data after CGS
        send_valid(32'h1C000102, 4'b1000, 4'h0, 32'h1C000102, 4'b1000, 4'h0);
        send_valid(32'hDEADBEEF, 4'b0000, 4'h0, 32'h01234567, 4'b0000, 4'h0);
        send_valid(32'h1C7C0000, 4'b1100, 4'h0, 32'hBCBCBC00, 4'b1110, 4'h0);
        drive(c_K32, 4'hF, 4'h0, c_K32, 4'hF, 4'h0);
        repeat (2) tick();

        // Three errors then a clean word: no drop
        repeat (3) send_valid(32'h1C000102, 4'b1000, 4'hF, 32'h00112233, 4'b0000, 4'h0);
        send_valid(32'h1C000102, 4'b1000, 4'h0, 32'h00112233, 4'b0000, 4'h0);
        chk("no_drop_sync", 64'(o_lane_sync), 64'd3);
        chk("no_drop_nsync", 64'(o_nsync), 64'd1);
        // Four errors: lane 0 back to hunt
        repeat (4) send_valid(32'h1C000102, 4'b1000, 4'h1, 32'h00112233, 4'b0000, 4'h0);
        chk("drop_sync", 64'(o_lane_sync), 64'd2);
        chk("drop_nsync_hold", 64'(o_nsync), 64'd1);
        drive(32'h55AA1234, 4'h0, 4'h0, 32'h00112233, 4'h0, 4'h0);
        tick();
        chk("drop_nsync_fall", 64'(o_nsync), 64'd0);
        chk("drop_valid_fall", 64'(o_data_valid), 64'd0);
        drive(c_K32, 4'hF, 4'h0, c_K32, 4'hF, 4'h0);
        repeat (3) tick();
        chk("relock_early", 64'(o_lane_sync), 64'd2);
        tick();
        chk("relock", 64'(o_lane_sync), 64'd3);
        tick();
        chk("relock_nsync", 64'(o_nsync), 64'd1);

        // Lane 1 carries a rotated comma for three hunt windows
        drive(c_K32, 4'hF, 4'h0, 32'h00BC0000, 4'b0100, 4'h0);
        gt_ready = 1'b0;
        tick();
        chk("restart_idle", 64'(o_lane_sync), 64'd0);
        push_slides(2'b10, 3);
        gt_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 400 && pulses < 3; i++) begin
            tick();
            if (o_rxslide[1]) pulses++;
        end
        chk("rot_pulses", 64'(pulses), 64'd3);
        chk("rot_lane_sync", 64'(o_lane_sync), 64'd1);
        chk("rot_nsync", 64'(o_nsync), 64'd0);
        drive(c_K32, 4'hF, 4'h0, c_K32, 4'hF, 4'h0);
        repeat (36) tick();
        chk("rot_lock_early", 64'(o_lane_sync), 64'd1);
        tick();
        chk("rot_lock", 64'(o_lane_sync), 64'd3);
        chk("rot_nsync_pre", 64'(o_nsync), 64'd0);
        tick();
        chk("rot_nsync_rise", 64'(o_nsync), 64'd1);

        // Lane 0 never aligns: fail flag after 40 slides, sliding continues
        drive(32'h00000000, 4'h0, 4'h0, c_K32, 4'hF, 4'h0);
        gt_ready = 1'b0;
        tick();
        push_slides(2'b01, 41);
        gt_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3000 && pulses < 41; i++) begin
            tick();
            if (o_rxslide[0]) begin
                pulses++;
                if (pulses == 40) begin
                    chk("fail_before", 64'(o_align_fail), 64'd0);
                    tick();
                    chk("fail_set", 64'(o_align_fail), 64'd1);
                    chk("fail_lane1_sync", 64'(o_lane_sync), 64'd2);
                end
            end
        end
        chk("fail_pulses", 64'(pulses), 64'd41);

        // Drop gt_ready with lane 0 in WAIT and lane 1 in SYNC
        repeat (5) tick();
        gt_ready = 1'b0;
        tick();
        chk("gtdrop_sync", 64'(o_lane_sync), 64'd0);
        chk("gtdrop_slide", 64'(o_rxslide), 64'd0);
        chk("gtdrop_fail_sticky", 64'(o_align_fail), 64'd1);
        tick();
        chk("gtdrop_nsync", 64'(o_nsync), 64'd0);
        repeat (100) tick();

        // Asynchronous reset while lane 0 is in SLIDE
        gt_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (o_rxslide[0]) found = 1'b1;
        end
        chk("slide_found", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_rxslide", 64'(o_rxslide), 64'd0);
        chk("arst_lane_sync", 64'(o_lane_sync), 64'd0);
        chk("arst_nsync", 64'(o_nsync), 64'd0);
        chk("arst_data", o_data, 64'd0);
        chk("arst_valid", 64'(o_data_valid), 64'd0);
        chk("arst_fail", 64'(o_align_fail), 64'd0);
        gt_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        chk("data_queue_empty", 64'(exp_data.size()), 64'd0);
        chk("slide_queue_empty", 64'(exp_mask.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
